// File: rtl/sub_bytes_seq.sv
// Forward AES SubBytes engine: takes a 128-bit state over valid/ready,
// substitutes BYTES_PER_CYCLE bytes per clock through the forward S-box,
// and returns the result over a second valid/ready handshake.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake, state_in carries the state
//   out_valid/out_ready output handshake, state_out carries the result
//   busy                high while bytes are being substituted
// Byte 0 of a state is bits [127:120], byte 15 is bits [7:0].
module sub_bytes_seq #(
   parameter int BYTES_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] state_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] state_out,
   output logic         busy
);

   localparam bit LEGAL = (BYTES_PER_CYCLE == 1) ||
                          (BYTES_PER_CYCLE == 2) ||
                          (BYTES_PER_CYCLE == 4) ||
                          (BYTES_PER_CYCLE == 8) ||
                          (BYTES_PER_CYCLE == 16);

   if (!LEGAL) begin : g_bad_param
      $error("sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
   end

   localparam int CNT_W = $clog2(16);

   // STEP truncates to 0 for 16 bytes/cycle; the counter then never moves.
   localparam logic [CNT_W-1:0] STEP = CNT_W'(BYTES_PER_CYCLE);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(16 - BYTES_PER_CYCLE);

   // Forward S-box, entry 0x00 in the top byte, entry 0xFF in the bottom.
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[11'd2047 - {x, 3'b000} -: 8];
   endfunction

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   state_t             r_fsm;
   state_t             w_nxt;
   logic [127:0]       r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [127:0]       w_sub;
   logic               w_last;

   assign w_last = (r_cnt == LAST);

   // Substitute the current group of bytes in the working register.
   always_comb begin
      w_sub = r_state;
      for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
         w_sub[7'd127 - {r_cnt + 4'(j), 3'b000} -: 8] =
            sbox(r_state[7'd127 - {r_cnt + 4'(j), 3'b000} -: 8]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_fsm <= S_IDLE;
      else     r_fsm <= w_nxt;
   end

   always_comb begin
      w_nxt = r_fsm;
      unique case (r_fsm)
         S_IDLE: if (in_valid)  w_nxt = S_BUSY;
         S_BUSY: if (w_last)    w_nxt = S_DONE;
         S_DONE: if (out_ready) w_nxt = S_IDLE;
         default:               w_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= '0;
         r_cnt   <= '0;
      end else begin
         unique case (r_fsm)
            S_IDLE: begin
               if (in_valid) begin
                  r_state <= state_in;
                  r_cnt   <= '0;
               end
            end
            S_BUSY: begin
               r_state <= w_sub;
               r_cnt   <= r_cnt + STEP;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      in_ready  = (r_fsm == S_IDLE);
      busy      = (r_fsm == S_BUSY);
      out_valid = (r_fsm == S_DONE);
      state_out = (r_fsm == S_DONE) ? r_state : '0;
   end

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Directed bench for sub_bytes_seq: one instance per legal group size,
// hand-computed vectors plus a GF(2^8) reference model for the sweep.
module tb_sub_bytes_seq;

   logic         clk;
   logic         rst;
   logic         out_ready;
   logic [127:0] state_in;
   logic         iv [5];
   logic         ir [5];
   logic         ov [5];
   logic         bz [5];
   logic [127:0] so [5];

   int total;
   int bad;

   for (genvar g = 0; g < 5; g++) begin : g_dut
      sub_bytes_seq #(.BYTES_PER_CYCLE(1 << g)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (iv[g]),
         .in_ready  (ir[g]),
         .state_in  (state_in),
         .out_valid (ov[g]),
         .out_ready (out_ready),
         .state_out (so[g]),
         .busy      (bz[g])
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic       hi;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         hi = a[7];
         a  = {a[6:0], 1'b0};
         if (hi) a = a ^ 8'h1b;
         b  = {1'b0, b[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] ginv(input logic [7:0] x);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 0; i < 254; i++) r = gmul(r, x);
      return r;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   function automatic logic [7:0] fwd_model(input logic [7:0] x);
      logic [7:0] b;
      b = ginv(x);
      return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_model(input logic [7:0] s);
      return ginv(rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05);
   endfunction

   task automatic chki(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input int k, input logic [127:0] d);
      state_in = d;
      iv[k]    = 1'b1;
      step();
      iv[k]    = 1'b0;
      chki("acc_busy", int'(bz[k]), 1);
      chki("acc_rdy", int'(ir[k]), 0);
   endtask

   task automatic wait_valid(input int k, input int exp_lat, input string tag);
      int lat;
      lat = 0;
      while (!ov[k] && lat < 100) begin
         step();
         lat++;
      end
      chki(tag, lat, exp_lat);
   endtask

   task automatic drain(input int k);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chki("drain_ov", int'(ov[k]), 0);
      chki("drain_rdy", int'(ir[k]), 1);
   endtask

   logic [7:0]   t1_in  [9];
   logic [7:0]   t1_exp [9];
   logic [127:0] v5 [4];
   logic [127:0] e5 [4];
   bit           seen [256];

   initial begin
      int           nres;
      int           last;
      int           idx;
      int           cnt;
      bit           acc;
      logic [127:0] d;
      logic [7:0]   x;
      logic [7:0]   y;

      total     = 0;
      bad       = 0;
      rst       = 1'b1;
      out_ready = 1'b0;
      state_in  = '0;
      for (int k = 0; k < 5; k++) iv[k] = 1'b0;

      t1_in  = '{8'h00, 8'h23, 8'h56, 8'ha3, 8'h4e,
                 8'h19, 8'hff, 8'hcc, 8'hdf};
      t1_exp = '{8'h63, 8'h26, 8'hb1, 8'h0a, 8'h2f,
                 8'hd4, 8'h16, 8'h4b, 8'h9e};
      v5 = '{128'h0, {16{8'h01}}, FIPS_IN,
             128'h000102030405060708090a0b0c0d0e0f};
      e5 = '{{16{8'h63}}, {16{8'h7c}}, FIPS_OUT,
             128'h637c777bf26b6fc53001672bfed7ab76};

      step();
      step();
      for (int k = 0; k < 5; k++) begin
         chki("rst_rdy", int'(ir[k]), 1);
         chki("rst_ov", int'(ov[k]), 0);
         chki("rst_busy", int'(bz[k]), 0);
         chkw("rst_out", so[k], 128'h0);
      end
      rst = 1'b0;
      step();

      // Single bytes through the 1-byte engine.
      for (int i = 0; i < 9; i++) begin
         accept(0, {t1_in[i], 120'h0});
         wait_valid(0, 16, "t1_lat");
         chkw("t1_out", so[0], {t1_exp[i], {15{8'h63}}});
         drain(0);
      end

      // FIPS-197 round-1 vector on every group size.
      for (int k = 0; k < 5; k++) begin
         accept(k, FIPS_IN);
         wait_valid(k, 16 >> k, "t2_lat");
         chkw("t2_out", so[k], FIPS_OUT);
         drain(k);
      end

      // Output held under backpressure, new input refused.
      accept(0, FIPS_IN);
      wait_valid(0, 16, "t3_lat");
      chkw("t3_out0", so[0], FIPS_OUT);
      for (int i = 0; i < 20; i++) begin
         if (i == 3) begin
            state_in = v5[3];
            iv[0]    = 1'b1;
         end
         if (i == 6) iv[0] = 1'b0;
         step();
         chki("t3_ov", int'(ov[0]), 1);
         chkw("t3_out", so[0], FIPS_OUT);
         chki("t3_rdy", int'(ir[0]), 0);
      end
      drain(0);
      chki("t3_busy", int'(bz[0]), 0);

      // Reset in the middle of a substitution.
      accept(0, FIPS_IN);
      for (int i = 0; i < 7; i++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chki("t4_ov", int'(ov[0]), 0);
      chki("t4_rdy", int'(ir[0]), 1);
      chki("t4_busy", int'(bz[0]), 0);
      chkw("t4_out", so[0], 128'h0);
      accept(0, v5[3]);
      wait_valid(0, 16, "t4_lat");
      chkw("t4_data", so[0], e5[3]);
      drain(0);

      // Streaming on the 4-byte engine with both handshakes held high.
      idx       = 0;
      nres      = 0;
      last      = 0;
      state_in  = v5[0];
      iv[2]     = 1'b1;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 60; cyc++) begin
         acc = ir[2] && iv[2];
         step();
         if (acc) begin
            idx++;
            if (idx == 4) iv[2] = 1'b0;
            else          state_in = v5[idx];
         end
         if (ov[2]) begin
            if (nres < 4) chkw("t5_out", so[2], e5[nres]);
            if (nres > 0) chki("t5_gap", cyc - last, 6);
            last = cyc;
            nres++;
         end
      end
      out_ready = 1'b0;
      iv[2]     = 1'b0;
      chki("t5_count", nres, 4);

      // Every byte value on every engine, checked against the GF model.
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < 256; i++) seen[i] = 1'b0;
         for (int blk = 0; blk < 16; blk++) begin
            for (int j = 0; j < 16; j++) d[127 - 8*j -: 8] = 8'(blk*16 + j);
            accept(k, d);
            wait_valid(k, 16 >> k, "t6_lat");
            for (int j = 0; j < 16; j++) begin
               x = 8'(blk*16 + j);
               y = so[k][127 - 8*j -: 8];
               chki("t6_fwd", int'(y), int'(fwd_model(x)));
               chki("t6_inv", int'(inv_model(y)), int'(x));
               seen[y] = 1'b1;
            end
            drain(k);
         end
         cnt = 0;
         for (int i = 0; i < 256; i++) if (seen[i]) cnt++;
         chki("t6_distinct", cnt, 256);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
